// File: rtl/seq_detector_param_if.sv
// Symbol stream, configuration and status bundle for seq_detector_param.
// The master side drives symbols and configuration; the slave side reports matches.
interface seq_detector_param_if #(
    parameter int WIDTH = 2,
    parameter int DEPTH = 4,
    parameter int CNT_W = 8
);
    logic                   valid;
    logic [WIDTH-1:0]       sym;
    logic                   cfg_load;
    logic [DEPTH*WIDTH-1:0] cfg_pattern;
    logic                   cfg_overlap;
    logic                   q;
    logic [CNT_W-1:0]       match_count;
    logic                   configured;

    modport master (
        output valid, sym, cfg_load, cfg_pattern, cfg_overlap,
        input  q, match_count, configured
    );

    modport slave (
        input  valid, sym, cfg_load, cfg_pattern, cfg_overlap,
        output q, match_count, configured
    );
endinterface

// File: rtl/seq_detector_param.sv
// Moore sequence detector with a runtime-loadable DEPTH-symbol pattern,
// optional overlapping matches and a saturating match counter.
module seq_detector_param #(
    parameter int WIDTH = 2,
    parameter int DEPTH = 4,
    parameter int CNT_W = 8
) (
    input logic                 clock,
    input logic                 reset,
    seq_detector_param_if.slave bus
);
    localparam int TOT = DEPTH * WIDTH;
    localparam int FW  = $clog2(DEPTH + 1);
    localparam logic [FW-1:0] FULL = FW'(DEPTH);

    typedef enum logic [1:0] {
        UNCONF,
        HUNT,
        MATCH
    } state_t;

    state_t           state;
    logic [TOT-1:0]   hist;
    logic [TOT-1:0]   pat;
    logic             ovl;
    logic [FW-1:0]    fill;
    logic [CNT_W-1:0] cnt;
    logic             q_r;
    logic             conf_r;

    logic [TOT-1:0]   hist_n;
    logic [FW-1:0]    fill_n;
    logic             accept;
    logic             hit;

    // Newest symbol enters at the top, so the oldest sits where pattern symbol 0 lives.
    always_comb begin
        hist_n = {bus.sym, hist[TOT-1:WIDTH]};
        fill_n = (fill == FULL) ? fill : fill + 1'b1;
        accept = bus.valid && !bus.cfg_load && (state != UNCONF);
        hit    = (fill_n == FULL) && (hist_n == pat);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state  <= UNCONF;
            hist   <= '0;
            pat    <= '0;
            ovl    <= 1'b0;
            fill   <= '0;
            cnt    <= '0;
            q_r    <= 1'b0;
            conf_r <= 1'b0;
        end else if (bus.cfg_load) begin
            state  <= HUNT;
            hist   <= '0;
            pat    <= bus.cfg_pattern;
            ovl    <= bus.cfg_overlap;
            fill   <= '0;
            cnt    <= '0;
            q_r    <= 1'b0;
            conf_r <= 1'b1;
        end else begin
            unique case (state)
                UNCONF: begin
                    q_r <= 1'b0;
                end
                HUNT, MATCH: begin
                    if (accept && hit) begin
                        state <= MATCH;
                        q_r   <= 1'b1;
                        hist  <= hist_n;
                        fill  <= ovl ? FULL : '0;
                        if (cnt != '1)
                            cnt <= cnt + 1'b1;
                    end else begin
                        state <= HUNT;
                        q_r   <= 1'b0;
                        if (accept) begin
                            hist <= hist_n;
                            fill <= fill_n;
                        end
                    end
                end
                default: begin
                    state <= UNCONF;
                    q_r   <= 1'b0;
                end
            endcase
        end
    end

    assign bus.q           = q_r;
    assign bus.match_count = cnt;
    assign bus.configured  = conf_r;
endmodule

// File: tb/tb_seq_detector_param.sv
// Self-checking bench for seq_detector_param: directed scenarios then
// randomized traffic, all checked against a queue-based reference model.
module tb_seq_detector_param;
    localparam int WIDTH = 2;
    localparam int DEPTH = 3;
    localparam int CNT_W = 2;
    localparam int CMAX  = (1 << CNT_W) - 1;

    logic clock;
    logic reset;

    seq_detector_param_if #(
        .WIDTH(WIDTH),
        .DEPTH(DEPTH),
        .CNT_W(CNT_W)
    ) bus ();

    seq_detector_param #(
        .WIDTH(WIDTH),
        .DEPTH(DEPTH),
        .CNT_W(CNT_W)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus.slave)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;
    int pulses = 0;
    string phase = "init";

    // reference model state
    logic [WIDTH-1:0]       win[$];
    logic [DEPTH*WIDTH-1:0] m_pat = '0;
    bit                     m_ovl = 0;
    bit                     m_conf = 0;
    bit                     m_q = 0;
    int                     m_cnt = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s.%s got %0h expected %0h", phase, tag, got, exp);
        end
    endtask

    function automatic bit win_hit();
        logic [WIDTH-1:0] ps;
        if (win.size() != DEPTH) return 0;
        for (int i = 0; i < DEPTH; i++) begin
            ps = m_pat[i*WIDTH +: WIDTH];
            if (win[i] != ps) return 0;
        end
        return 1;
    endfunction

    task automatic model(input logic v, input logic [WIDTH-1:0] s,
                         input logic ld, input logic [DEPTH*WIDTH-1:0] p,
                         input logic o);
        m_q = 0;
        if (ld) begin
            m_pat  = p;
            m_ovl  = o;
            m_conf = 1;
            m_cnt  = 0;
            win.delete();
        end else if (m_conf && v) begin
            win.push_back(s);
            if (win.size() > DEPTH) void'(win.pop_front());
            if (win_hit()) begin
                m_q = 1;
                if (m_cnt < CMAX) m_cnt++;
                if (!m_ovl) win.delete();
            end
        end
    endtask

    task automatic model_reset();
        m_pat  = '0;
        m_ovl  = 0;
        m_conf = 0;
        m_q    = 0;
        m_cnt  = 0;
        win.delete();
    endtask

    task automatic check_outs();
        chk("q", {31'd0, bus.q}, {31'd0, m_q});
        chk("cnt", 32'(bus.match_count), 32'(m_cnt));
        chk("conf", {31'd0, bus.configured}, {31'd0, m_conf});
    endtask

    // one clock: drive at posedge+1, sample at next posedge+1
    task automatic step(input logic v, input logic [WIDTH-1:0] s,
                        input logic ld, input logic [DEPTH*WIDTH-1:0] p,
                        input logic o);
        bus.valid       = v;
        bus.sym         = s;
        bus.cfg_load    = ld;
        bus.cfg_pattern = p;
        bus.cfg_overlap = o;
        @(posedge clock);
        #1;
        model(v, s, ld, p, o);
        check_outs();
        if (bus.q) pulses++;
        bus.valid    = 1'b0;
        bus.cfg_load = 1'b0;
    endtask

    task automatic feed(input logic [WIDTH-1:0] s);
        step(1'b1, s, 1'b0, '0, 1'b0);
    endtask

    task automatic load(input logic [DEPTH*WIDTH-1:0] p, input logic o);
        step(1'b0, '0, 1'b1, p, o);
    endtask

    task automatic idle();
        step(1'b0, '0, 1'b0, '0, 1'b0);
    endtask

    initial begin
        logic v;
        logic ld;
        logic o;
        logic [WIDTH-1:0] s;
        logic [DEPTH*WIDTH-1:0] p;

        reset           = 1'b0;
        bus.valid       = 1'b0;
        bus.sym         = '0;
        bus.cfg_load    = 1'b0;
        bus.cfg_pattern = '0;
        bus.cfg_overlap = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        phase = "por";
        check_outs();
        reset = 1'b1;

        // async reset while q is high and valid is asserted
        phase = "rst";
        load(6'b11_11_11, 1'b1);
        repeat (3) feed(2'b11);
        chk("q_pre", {31'd0, bus.q}, 32'd1);
        bus.valid = 1'b1;
        bus.sym   = 2'b11;
        #2;
        reset = 1'b0;
        #1;
        model_reset();
        check_outs();
        @(posedge clock);
        #1;
        check_outs();
        reset = 1'b1;
        bus.valid = 1'b0;

        phase = "unconf";
        for (int i = 0; i < 4; i++) feed(2'b11);
        idle();

        phase = "basic";
        load(6'b01_11_10, 1'b0);
        feed(2'b10);
        feed(2'b11);
        feed(2'b01);
        chk("q_hit", {31'd0, bus.q}, 32'd1);
        idle();
        chk("q_drop", {31'd0, bus.q}, 32'd0);
        chk("cnt1", 32'(bus.match_count), 32'd1);
        feed(2'b10);
        feed(2'b11);
        feed(2'b00);
        chk("cnt_miss", 32'(bus.match_count), 32'd1);

        phase = "ovl1";
        load(6'b11_11_11, 1'b1);
        pulses = 0;
        for (int i = 0; i < 5; i++) feed(2'b11);
        chk("pulses", 32'(pulses), 32'd3);
        chk("cnt", 32'(bus.match_count), 32'd3);

        phase = "ovl0";
        load(6'b11_11_11, 1'b0);
        pulses = 0;
        for (int i = 0; i < 5; i++) feed(2'b11);
        chk("pulses5", 32'(pulses), 32'd1);
        feed(2'b11);
        chk("pulses6", 32'(pulses), 32'd2);
        chk("cnt", 32'(bus.match_count), 32'd2);

        phase = "gaps";
        load(6'b01_11_10, 1'b0);
        pulses = 0;
        feed(2'b10);
        idle();
        idle();
        feed(2'b11);
        idle();
        idle();
        feed(2'b01);
        idle();
        idle();
        chk("pulses", 32'(pulses), 32'd1);
        chk("cnt", 32'(bus.match_count), 32'd1);

        phase = "reload";
        feed(2'b10);
        feed(2'b11);
        pulses = 0;
        step(1'b1, 2'b01, 1'b1, 6'b00_00_00, 1'b0);
        chk("cnt0", 32'(bus.match_count), 32'd0);
        for (int i = 0; i < 3; i++) feed(2'b00);
        chk("pulses", 32'(pulses), 32'd1);
        chk("cnt1", 32'(bus.match_count), 32'd1);

        phase = "sat";
        load(6'b11_11_11, 1'b1);
        pulses = 0;
        for (int i = 0; i < 7; i++) feed(2'b11);
        chk("pulses", 32'(pulses), 32'd5);
        chk("cnt", 32'(bus.match_count), 32'd3);

        phase = "rand";
        for (int i = 0; i < 3000; i++) begin
            v  = ($urandom % 4) != 0;
            ld = ($urandom % 50) == 0;
            o  = 1'(($urandom % 2));
            s  = ($urandom % 2 == 0) ? 2'b11 : 2'($urandom_range(0, 3));
            for (int k = 0; k < DEPTH; k++)
                p[k*WIDTH +: WIDTH] =
                    ($urandom % 2 == 0) ? 2'b11 : 2'($urandom_range(0, 3));
            step(v, s, ld, p, o);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/seq_detector_param.md
Name: seq_detector_param

Overview:
- Parametrised Moore-style sequence detector on a WIDTH-bit symbol stream.
- Runtime-loadable pattern of DEPTH symbols, selectable overlapping or non-overlapping matching, and a saturating match counter.
- Generalises the team's fixed two-input (a, b) detector FSMs. It sits between stimulus/decode logic and status logic.

Parameters:
- WIDTH, 2, bits per symbol; WIDTH=2 corresponds to {a,b}.
- DEPTH, 4, pattern length in symbols (>=2).
- CNT_W, 8, width of the match counter.

Ports:
- clock  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- valid  input  1  sym is presented this cycle.
- sym  input  WIDTH  input symbol.
- cfg_load  input  1  capture cfg_pattern and cfg_overlap this cycle.
- cfg_pattern  input  DEPTH*WIDTH  pattern; bits [WIDTH-1:0] are the first symbol expected, the top slice is the last.
- cfg_overlap  input  1  1 = overlapping matches allowed.
- q  output  1  registered match pulse.
- match_count  output  CNT_W  saturating count of matches since last reset or cfg_load.
- configured  output  1  a pattern has been loaded since reset.

Behaviour:
- Reset (reset=0, asynchronous): state UNCONF.
  - q=0, match_count=0, configured=0.
  - History and fill counter are cleared; pattern and overlap registers are cleared.
  - Outputs drop immediately without waiting for a clock edge.
- Storage:
  - DEPTH-entry history shift register.
  - Fill counter, 0..DEPTH, saturating at DEPTH.
  - Pattern register and overlap register.
- Acceptance: a symbol is accepted on a rising edge with valid=1 and cfg_load=0, in state HUNT. Cycles with valid=0 leave the history, fill counter and state unchanged; gaps never break a partial match.
- States:
  - UNCONF: symbols ignored. cfg_load -> HUNT.
  - HUNT: accepted symbol shifts into the history (newest at the top). Let fill' = min(fill+1, DEPTH).
    - If fill' = DEPTH and the shifted history equals the pattern: next state MATCH, and match_count increments.
    - Otherwise stay in HUNT with fill=fill'.
  - MATCH: lasts exactly one cycle; q=1 only in this state.
    - On the edge leaving MATCH, a symbol accepted that cycle is processed exactly as in HUNT. Consecutive matches therefore hold MATCH with q=1 for consecutive cycles.
- Overlap on a match:
  - cfg_overlap=1: history and fill are kept at DEPTH, so the next symbol can complete a new match.
  - cfg_overlap=0: fill is cleared to 0, so the next match needs DEPTH fresh symbols.
- Latency: q rises on the edge that accepts the final pattern symbol, i.e. it is visible the cycle after sym is presented (Moore).
- cfg_load behaviour:
  - Captures pattern and overlap; history, fill and match_count are cleared.
  - State -> HUNT; q=0 next cycle; configured=1.
  - Allowed in any state. When cfg_load and valid occur together, cfg_load wins and the symbol is discarded.
- match_count saturates at 2^CNT_W-1. q still pulses on matches after saturation.
- Equality compares all DEPTH*WIDTH bits. There are no don't-care symbols.

Test Plan:
- Reset/unconfigured: reset=0 while valid=1 and q forced high mid-run -> q=0, match_count=0, configured=0 immediately. After release, feed symbols without cfg_load -> q stays 0, count 0.
- Basic match (WIDTH=2, DEPTH=3): cfg_pattern=6'b01_11_10, overlap=0; feed 10,11,01 on consecutive cycles -> q=1 for exactly the cycle after 01; match_count=1. Feeding 10,11,00 -> no pulse.
- Overlap: pattern 6'b11_11_11, five consecutive sym=11.
  - overlap=1 -> q high on cycles after symbols 3, 4 and 5; count=3.
  - Reload with overlap=0 and repeat -> single pulse after symbol 3; count=1. A sixth 11 -> second pulse; count=2.
- Valid gaps: pattern 10,11,01 with valid=0 for 2 cycles between each symbol -> exactly one q pulse, after 01 is accepted; count=1.
- Reload mid-sequence: after accepting 10,11, assert cfg_load with valid=1, sym=01 and pattern 6'b00_00_00 -> no pulse, count=0. Then feed 00,00,00 -> one pulse, count=1.
- Saturation (CNT_W=2): overlap=1, pattern all 11, feed 7 symbols of 11 -> 5 q pulses; match_count sticks at 3.
